// File: rtl/sata_link_tx_framer.sv
// SATA link-layer TX framer: drains one frame from the show-ahead TX FIFO and
// emits SOF, data dwords, CRC and EOF, inserting HOLD on underrun and HOLDA on far-end hold.
module sata_link_tx_framer #(
   parameter logic [31:0] CRC_INIT   = 32'h52325032,
   parameter int unsigned MAX_DWORDS = 2049
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] fifo_data,
   input  logic        fifo_eop,
   input  logic        fifo_err,
   input  logic        fifo_empty,
   output logic        fifo_rdreq,
   input  logic        frm_go,
   input  logic        frm_hold,
   input  logic        frm_abort,
   output logic [31:0] frm_data,
   output logic [2:0]  frm_kind,
   output logic        frm_valid,
   output logic        frm_busy,
   output logic        frm_done,
   output logic        frm_bad
);

   localparam int unsigned DW = 32;
   localparam int unsigned KW = 3;
   localparam int unsigned CW = $clog2(MAX_DWORDS + 1);
   localparam logic [DW-1:0] POLY = 32'h04C11DB7;

   localparam logic [KW-1:0] K_DATA  = 3'd0;
   localparam logic [KW-1:0] K_SOF   = 3'd1;
   localparam logic [KW-1:0] K_CRC   = 3'd2;
   localparam logic [KW-1:0] K_EOF   = 3'd3;
   localparam logic [KW-1:0] K_HOLD  = 3'd4;
   localparam logic [KW-1:0] K_HOLDA = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SOF   = 3'd1,
      S_DATA  = 3'd2,
      S_CRC   = 3'd3,
      S_EOF   = 3'd4,
      S_DRAIN = 3'd5
   } state_e;

   state_e        state_q, state_d;

   logic [DW-1:0] crc_q, crc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bad_q, bad_d;
   logic          ovl_q, ovl_d;

   logic [DW-1:0] data_q, data_d;
   logic [KW-1:0] kind_q, kind_d;
   logic          valid_q, valid_d;
   logic          busy_q;
   logic          done_q, done_d;
   logic          badp_q, badp_d;

   logic          at_max_c;

   // One dword of MSB-first CRC-32 (poly 0x04C11DB7, no reflection, no final XOR)
   function automatic logic [DW-1:0] crc_step(input logic [DW-1:0] crc, input logic [DW-1:0] d);
      logic [DW-1:0] c;
      c = crc;
      for (int i = int'(DW) - 1; i >= 0; i--) begin
         if (c[DW-1] ^ d[i]) c = {c[DW-2:0], 1'b0} ^ POLY;
         else                c = {c[DW-2:0], 1'b0};
      end
      return c;
   endfunction

   // The dword popped this cycle would be the last one allowed in the frame
   assign at_max_c = ((cnt_q + CW'(1)) == CW'(MAX_DWORDS));

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (frm_go) state_d = S_SOF;
         end
         S_SOF: begin
            state_d = frm_abort ? S_DRAIN : S_DATA;
         end
         S_DATA: begin
            if (frm_abort)                              state_d = (fifo_rdreq && fifo_eop) ? S_IDLE : S_DRAIN;
            else if (fifo_rdreq && (fifo_eop || at_max_c)) state_d = S_CRC;
         end
         S_CRC: begin
            state_d = S_EOF;
         end
         S_EOF: begin
            state_d = ovl_q ? S_DRAIN : S_IDLE;
         end
         S_DRAIN: begin
            if (fifo_rdreq && fifo_eop) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pop control, next output word and frame bookkeeping
   always_comb begin
      fifo_rdreq = 1'b0;
      data_d     = '0;
      kind_d     = K_DATA;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      badp_d     = 1'b0;
      crc_d      = crc_q;
      cnt_d      = cnt_q;
      bad_d      = bad_q;
      ovl_d      = ovl_q;
      case (state_q)
         S_SOF: begin
            crc_d = CRC_INIT;
            cnt_d = '0;
            bad_d = 1'b0;
            ovl_d = 1'b0;
            if (!frm_abort) begin
               valid_d = 1'b1;
               kind_d  = K_SOF;
            end
         end
         S_DATA: begin
            fifo_rdreq = !fifo_empty && !frm_hold;
            if (!frm_abort) begin
               if (frm_hold) begin
                  valid_d = 1'b1;
                  kind_d  = K_HOLDA;
               end else if (fifo_empty) begin
                  valid_d = 1'b1;
                  kind_d  = K_HOLD;
               end else begin
                  valid_d = 1'b1;
                  kind_d  = K_DATA;
                  data_d  = fifo_data;
                  crc_d   = crc_step(crc_q, fifo_data);
                  cnt_d   = cnt_q + CW'(1);
                  if (fifo_err) bad_d = 1'b1;
                  if (!fifo_eop && at_max_c) begin
                     bad_d = 1'b1;
                     ovl_d = 1'b1;
                  end
               end
            end
         end
         S_CRC: begin
            valid_d = 1'b1;
            kind_d  = K_CRC;
            data_d  = bad_q ? ~crc_q : crc_q;
         end
         S_EOF: begin
            valid_d = 1'b1;
            kind_d  = K_EOF;
            done_d  = 1'b1;
            badp_d  = bad_q;
         end
         S_DRAIN: begin
            fifo_rdreq = !fifo_empty;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q   <= CRC_INIT;
         cnt_q   <= '0;
         bad_q   <= 1'b0;
         ovl_q   <= 1'b0;
         data_q  <= '0;
         kind_q  <= K_DATA;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         badp_q  <= 1'b0;
      end else begin
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         bad_q   <= bad_d;
         ovl_q   <= ovl_d;
         data_q  <= data_d;
         kind_q  <= kind_d;
         valid_q <= valid_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= done_d;
         badp_q  <= badp_d;
      end
   end

   assign frm_data  = data_q;
   assign frm_kind  = kind_q;
   assign frm_valid = valid_q;
   assign frm_busy  = busy_q;
   assign frm_done  = done_q;
   assign frm_bad   = badp_q;

endmodule

// File: tb/tb_sata_link_tx_framer.sv
// Bench for sata_link_tx_framer: scenario table, abort/reset sequences and random frames
// checked against a queue-based FIFO and polynomial-division CRC reference.
module tb_sata_link_tx_framer;

   localparam int unsigned TB_MAX = 12;
   localparam logic [31:0] INIT   = 32'h52325032;
   localparam logic [32:0] POLY33 = 33'h104C11DB7;
   localparam int K_DATA = 0, K_SOF = 1, K_CRC = 2, K_EOF = 3, K_HOLD = 4, K_HOLDA = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fifo_data;
   logic        fifo_eop, fifo_err, fifo_empty, fifo_rdreq;
   logic        frm_go, frm_hold, frm_abort;
   logic [31:0] frm_data;
   logic [2:0]  frm_kind;
   logic        frm_valid, frm_busy, frm_done, frm_bad;

   always #5 clk = ~clk;

   sata_link_tx_framer #(.CRC_INIT(INIT), .MAX_DWORDS(TB_MAX)) dut (
      .clk(clk), .reset(reset),
      .fifo_data(fifo_data), .fifo_eop(fifo_eop), .fifo_err(fifo_err),
      .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
      .frm_go(frm_go), .frm_hold(frm_hold), .frm_abort(frm_abort),
      .frm_data(frm_data), .frm_kind(frm_kind), .frm_valid(frm_valid),
      .frm_busy(frm_busy), .frm_done(frm_done), .frm_bad(frm_bad)
   );

   typedef struct {
      logic [31:0] d;
      logic        eop;
      logic        err;
   } fword_t;

   typedef struct {
      string       tag;
      int          n;
      logic [31:0] base;
      int          err_idx;
      int          preload;
      int          rel;
      int          hs;
      int          hl;
      int          exp_valid;
      int          exp_stalls;
   } row_t;

   fword_t fq[$];
   fword_t pend[$];
   int     checks   = 0;
   int     failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // CRC as remainder of ((crc ^ word) * x^32) mod P, by long division
   function automatic logic [31:0] ref_crc(input logic [31:0] w[$]);
      logic [31:0] r;
      logic [63:0] m;
      r = INIT;
      foreach (w[k]) begin
         m = {r ^ w[k], 32'h0};
         for (int b = 63; b >= 32; b--)
            if (m[b]) m[b -: 33] = m[b -: 33] ^ POLY33;
         r = m[31:0];
      end
      return r;
   endfunction

   task automatic upd_fifo();
      fifo_empty = (fq.size() == 0);
      if (fq.size() != 0) begin
         fifo_data = fq[0].d;
         fifo_eop  = fq[0].eop;
         fifo_err  = fq[0].err;
      end else begin
         fifo_data = '0;
         fifo_eop  = 1'b0;
         fifo_err  = 1'b0;
      end
   endtask

   task automatic step(output logic popped, output logic hold_in, output logic empty_in);
      #1;
      popped   = fifo_rdreq && !fifo_empty;
      hold_in  = frm_hold;
      empty_in = fifo_empty;
      @(posedge clk);
      #1;
      if (popped) fq.delete(0);
      frm_go    = 1'b0;
      frm_abort = 1'b0;
      upd_fifo();
   endtask

   task automatic run_frame(input string tag, input int n, input logic [31:0] base, input int err_idx,
                            input int preload, input int rel, input int hs, input int hl,
                            input bit rnd, input int exp_valid, input int exp_stalls);
      logic [31:0] words[$];
      logic [31:0] dw[$];
      logic [31:0] exp_crc;
      fword_t      fw;
      int          obs_kind[$];
      logic [31:0] obs_data[$];
      int          nd, nvalid, nstall, ndone, nbadp, cyc, k;
      bit          exp_bad, seen_eof, gap, started, stall_ok, hold_pop, vdrain;
      logic        p, h, e;

      words.delete(); dw.delete(); pend.delete(); obs_kind.delete(); obs_data.delete();
      for (int i = 0; i < n; i++) words.push_back(base * 32'(i + 1));
      nd = (n > int'(TB_MAX)) ? int'(TB_MAX) : n;
      for (int i = 0; i < nd; i++) dw.push_back(words[i]);
      exp_bad = (err_idx >= 0 && err_idx < nd) || (n > int'(TB_MAX));
      exp_crc = ref_crc(dw) ^ {32{exp_bad}};
      for (int i = 0; i < n; i++) begin
         fw.d = words[i]; fw.eop = (i == n - 1); fw.err = (i == err_idx);
         pend.push_back(fw);
      end
      for (int i = 0; i < preload && pend.size() > 0; i++) fq.push_back(pend.pop_front());
      upd_fifo();

      nvalid = 0; nstall = 0; ndone = 0; nbadp = 0; cyc = 0;
      seen_eof = 0; gap = 0; started = 0; stall_ok = 1; hold_pop = 0;
      frm_go = 1'b1;
      while (!seen_eof && cyc < 400) begin
         if (rnd) begin
            frm_hold = ($urandom_range(0, 99) < 25);
            if (pend.size() > 0 && $urandom_range(0, 99) < 60) fq.push_back(pend.pop_front());
         end else begin
            frm_hold = (hs >= 0 && cyc >= hs && cyc < hs + hl);
            if (cyc == rel) while (pend.size() > 0) fq.push_back(pend.pop_front());
         end
         upd_fifo();
         step(p, h, e);
         if (h && p) hold_pop = 1;
         if (frm_valid) begin
            if (gap) stall_ok = stall_ok;
            nvalid++;
            started = 1;
            if (int'(frm_kind) == K_HOLD || int'(frm_kind) == K_HOLDA) begin
               nstall++;
               if (int'(frm_kind) != (h ? K_HOLDA : K_HOLD) || (!h && !e)) stall_ok = 0;
            end else begin
               obs_kind.push_back(int'(frm_kind));
               obs_data.push_back(frm_data);
            end
            if (int'(frm_kind) == K_EOF) seen_eof = 1;
         end else if (started) gap = 1;
         ndone += int'(frm_done);
         nbadp += int'(frm_bad);
         cyc++;
      end

      chk({tag, "_eof_seen"}, seen_eof, 1);
      chk({tag, "_stream_len"}, obs_kind.size(), nd + 3);
      for (int i = 0; i < nd + 3 && i < obs_kind.size(); i++) begin
         if (i == 0) begin
            chk({tag, "_sof_kind"}, obs_kind[i], K_SOF);
            chk({tag, "_sof_data"}, obs_data[i], 0);
         end else if (i <= nd) begin
            chk($sformatf("%s_data%0d_kind", tag, i - 1), obs_kind[i], K_DATA);
            chk($sformatf("%s_data%0d", tag, i - 1), obs_data[i], words[i - 1]);
         end else if (i == nd + 1) begin
            chk({tag, "_crc_kind"}, obs_kind[i], K_CRC);
            chk({tag, "_crc"}, obs_data[i], exp_crc);
         end else begin
            chk({tag, "_eof_kind"}, obs_kind[i], K_EOF);
         end
      end
      if (rnd) chk({tag, "_valid_cnt"}, nvalid, nd + 3 + nstall);
      else begin
         chk({tag, "_valid_cnt"}, nvalid, exp_valid);
         chk({tag, "_stall_cnt"}, nstall, exp_stalls);
      end
      chk({tag, "_contiguous"}, gap, 0);
      chk({tag, "_stall_kinds"}, stall_ok, 1);
      chk({tag, "_no_pop_in_hold"}, hold_pop, 0);
      chk({tag, "_done_pulses"}, ndone, 1);
      chk({tag, "_bad_pulses"}, nbadp, exp_bad);

      frm_hold = 1'b0;
      if (n > int'(TB_MAX)) begin
         k = 0; vdrain = 0;
         while (frm_busy && k < 50) begin
            step(p, h, e);
            if (frm_valid) vdrain = 1;
            k++;
         end
         chk({tag, "_drain_busy"}, frm_busy, 0);
         chk({tag, "_drain_quiet"}, vdrain, 0);
      end else begin
         chk({tag, "_busy_at_eof"}, frm_busy, 0);
      end
      chk({tag, "_fifo_left"}, fq.size() + pend.size(), 0);
      step(p, h, e);
      chk({tag, "_idle_after"}, frm_valid, 0);
   endtask

   row_t   tbl[8];
   fword_t fw;
   logic   p, h, e;
   int     nd, np, nbadk, ndn, k, rn, rerr;

   initial begin
      tbl[0] = '{"basic",      4, 32'h11111111, -1, 4,  0, -1, 0, 7,  0};
      tbl[1] = '{"hold",       4, 32'h11111111, -1, 4,  0,  4, 3, 10, 3};
      tbl[2] = '{"underrun",   3, 32'hA0000001, -1, 2,  9, -1, 0, 11, 5};
      tbl[3] = '{"err",        3, 32'h01020304,  1, 3,  0, -1, 0, 6,  0};
      tbl[4] = '{"single",     1, 32'hDEADBEEF, -1, 1,  0, -1, 0, 4,  0};
      tbl[5] = '{"exact_max", 12, 32'h00000101, -1, 12, 0, -1, 0, 15, 0};
      tbl[6] = '{"hold_empty", 3, 32'h0BADF00D, -1, 1,  6,  3, 2, 9,  3};
      tbl[7] = '{"overlength",15, 32'hC0DE0001, -1, 15, 0, -1, 0, 15, 0};

      reset = 1'b1; frm_go = 1'b0; frm_hold = 1'b0; frm_abort = 1'b0;
      upd_fifo();
      step(p, h, e);
      step(p, h, e);
      chk("rst_valid", frm_valid, 0);
      chk("rst_kind", frm_kind, 0);
      chk("rst_data", frm_data, 0);
      chk("rst_busy", frm_busy, 0);
      chk("rst_done", frm_done, 0);
      chk("rst_bad", frm_bad, 0);
      chk("rst_rdreq", fifo_rdreq, 0);
      reset = 1'b0;
      step(p, h, e);

      foreach (tbl[i])
         run_frame(tbl[i].tag, tbl[i].n, tbl[i].base, tbl[i].err_idx, tbl[i].preload,
                   tbl[i].rel, tbl[i].hs, tbl[i].hl, 1'b0, tbl[i].exp_valid, tbl[i].exp_stalls);

      // Abort after the 3rd DATA: the rest of the frame is discarded silently
      for (int i = 0; i < 8; i++) begin
         fw.d = 32'h0A000000 + 32'(i); fw.eop = (i == 7); fw.err = 1'b0;
         fq.push_back(fw);
      end
      upd_fifo();
      frm_go = 1'b1; nd = 0;
      for (int c = 0; c < 5; c++) begin
         step(p, h, e);
         if (frm_valid && int'(frm_kind) == K_DATA) nd++;
      end
      chk("abort_pre_data", nd, 3);
      frm_abort = 1'b1; np = 0; nbadk = 0; ndn = 0; k = 0;
      step(p, h, e);
      np += int'(p);
      if (frm_valid && (int'(frm_kind) == K_CRC || int'(frm_kind) == K_EOF)) nbadk++;
      ndn += int'(frm_done);
      while (frm_busy && k < 30) begin
         step(p, h, e);
         np += int'(p);
         if (frm_valid) nbadk++;
         ndn += int'(frm_done);
         k++;
      end
      chk("abort_pops", np, 5);
      chk("abort_fifo_empty", fq.size(), 0);
      chk("abort_busy", frm_busy, 0);
      chk("abort_no_crc_eof", nbadk, 0);
      chk("abort_no_done", ndn, 0);
      step(p, h, e);
      run_frame("post_abort", 1, 32'h5A5A5A5A, -1, 1, 0, -1, 0, 1'b0, 4, 0);

      // Abort coinciding with the eop pop goes straight back to idle
      for (int i = 0; i < 4; i++) begin
         fw.d = 32'h0B000000 + 32'(i); fw.eop = (i == 3); fw.err = 1'b0;
         fq.push_back(fw);
      end
      upd_fifo();
      frm_go = 1'b1;
      for (int c = 0; c < 5; c++) step(p, h, e);
      frm_abort = 1'b1;
      step(p, h, e);
      chk("abort_eop_pop", p, 1);
      chk("abort_eop_busy", frm_busy, 0);
      chk("abort_eop_fifo", fq.size(), 0);
      step(p, h, e);
      chk("abort_eop_quiet", frm_valid, 0);

      // Reset mid-DATA, FIFO flushed alongside
      for (int i = 0; i < 6; i++) begin
         fw.d = 32'h0C000000 + 32'(i); fw.eop = (i == 5); fw.err = 1'b0;
         fq.push_back(fw);
      end
      upd_fifo();
      frm_go = 1'b1;
      for (int c = 0; c < 4; c++) step(p, h, e);
      chk("mid_busy_before", frm_busy, 1);
      reset = 1'b1;
      step(p, h, e);
      fq.delete();
      upd_fifo();
      chk("mid_rst_valid", frm_valid, 0);
      chk("mid_rst_kind", frm_kind, 0);
      chk("mid_rst_data", frm_data, 0);
      chk("mid_rst_busy", frm_busy, 0);
      chk("mid_rst_done", frm_done, 0);
      chk("mid_rst_bad", frm_bad, 0);
      reset = 1'b0;
      step(p, h, e);
      chk("mid_rst_rdreq", fifo_rdreq, 0);
      run_frame("post_reset", 4, 32'h11111111, -1, 4, 0, -1, 0, 1'b0, 7, 0);

      for (int r = 0; r < 25; r++) begin
         rn   = int'($urandom_range(1, 10));
         rerr = ($urandom_range(0, 7) < 2) ? int'($urandom_range(0, rn - 1)) : -1;
         run_frame($sformatf("rnd%0d", r), rn, $urandom, rerr, int'($urandom_range(0, rn)),
                   0, -1, 0, 1'b1, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
